// File: rtl/nmi_bus_timeout.sv
// Transparent nmi-bus stage that bounds the time a core can wait on its target.
// A stalled request is completed to the core with ERR_RDATA, then drained downstream.
module nmi_bus_timeout #(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_addr_i,
  input  logic [31:0] s_wdata_i,
  input  logic [3:0]  s_wstrb_i,
  output logic [31:0] s_rdata_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_wstrb_o,
  input  logic [31:0] m_rdata_i,
  input  logic        to_clr_i,
  output logic        to_irq_o,
  output logic [31:0] to_addr_o,
  output logic [7:0]  to_cnt_o,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request is offered while valid is high and holds its payload
  // stable; it completes in the cycle where valid and ready are both high.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);
  localparam bit               TO_EN  = (TIMEOUT_CYC != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [3:0]       lat_wstrb;
  logic             timeout_hit;

  // A ready arriving on the last allowed cycle still wins over the timeout.
  assign timeout_hit = TO_EN && (state == ST_WAIT) && !m_ready_i && (cnt == TO_VAL);
  assign dbg_state_o = state;

  always_comb begin
    m_valid_o = s_valid_i;
    m_addr_o  = s_addr_i;
    m_wdata_o = s_wdata_i;
    m_wstrb_o = s_wstrb_i;
    s_ready_o = m_ready_i & s_valid_i;
    s_rdata_o = m_rdata_i;
    case (state)
      ST_WAIT: begin
        m_valid_o = 1'b1;
        m_addr_o  = lat_addr;
        m_wdata_o = lat_wdata;
        m_wstrb_o = lat_wstrb;
        s_ready_o = (m_ready_i & s_valid_i) | timeout_hit;
        if (timeout_hit) s_rdata_o = ERR_RDATA;
      end
      ST_DRAIN: begin
        m_valid_o = 1'b1;
        m_addr_o  = lat_addr;
        m_wdata_o = lat_wdata;
        m_wstrb_o = lat_wstrb;
        s_ready_o = 1'b0;
      end
      default: ;
    endcase
    // Outputs that start a handshake must not glitch high while reset is held.
    if (rst_i) begin
      m_valid_o = 1'b0;
      s_ready_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
      to_irq_o  <= 1'b0;
      to_addr_o <= '0;
      to_cnt_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_valid_i && !m_ready_i) begin
            lat_addr  <= s_addr_i;
            lat_wdata <= s_wdata_i;
            lat_wstrb <= s_wstrb_i;
            cnt       <= CNT_W'(1);
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (m_ready_i) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (timeout_hit) begin
            cnt   <= '0;
            state <= ST_DRAIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          // The late target response is swallowed; the core already got ERR_RDATA.
          if (m_ready_i) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A clear and a timeout in the same cycle leave exactly one event recorded.
      if (timeout_hit) begin
        to_irq_o  <= 1'b1;
        to_addr_o <= lat_addr;
        if (to_clr_i)               to_cnt_o <= 8'd1;
        else if (to_cnt_o != 8'hFF) to_cnt_o <= to_cnt_o + 8'd1;
      end else if (to_clr_i) begin
        to_irq_o <= 1'b0;
        to_cnt_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_nmi_bus_timeout.sv
// Bench for nmi_bus_timeout: core/target drivers, a response scoreboard and a
// transaction-level model of the timeout bookkeeping.
`timescale 1ns/1ps
module tb_nmi_bus_timeout;

  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam logic [1:0]  IDLE_ENC = 2'd0;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] s_addr_i = '0;
  logic [31:0] s_wdata_i = '0;
  logic [3:0]  s_wstrb_i = '0;
  logic [31:0] s_rdata_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic [31:0] m_rdata_i = '0;
  logic        to_clr_i = 1'b0;
  logic        to_irq_o;
  logic [31:0] to_addr_o;
  logic [7:0]  to_cnt_o;
  logic [1:0]  dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  // Transaction-level model of the software-visible timeout record.
  logic        mdl_irq  = 1'b0;
  logic [31:0] mdl_addr = '0;
  int          mdl_cnt  = 0;

  nmi_bus_timeout #(
    .TIMEOUT_CYC(TO),
    .CNT_W(16),
    .ERR_RDATA(ERR)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .s_addr_i(s_addr_i),
    .s_wdata_i(s_wdata_i),
    .s_wstrb_i(s_wstrb_i),
    .s_rdata_o(s_rdata_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o),
    .m_wstrb_o(m_wstrb_o),
    .m_rdata_i(m_rdata_i),
    .to_clr_i(to_clr_i),
    .to_irq_o(to_irq_o),
    .to_addr_o(to_addr_o),
    .to_cnt_o(to_cnt_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completion seen by the core is matched against the scoreboard.
  always @(negedge clk_i) begin
    if (!rst_i && s_ready_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion: rdata %0h with empty queue at %0t", s_rdata_o, $time);
      end else begin
        chk("s_rdata", s_rdata_o, exp_q.pop_front());
      end
    end
  end

  task automatic check_record();
    chk("to_irq", to_irq_o, mdl_irq);
    chk("to_cnt", to_cnt_o, mdl_cnt);
    chk("to_addr", to_addr_o, mdl_addr);
    chk("state_idle", dbg_state_o, IDLE_ENC);
  endtask

  // One core transaction; the target answers on cycle 'delay' counted from the
  // cycle valid rises. Optionally a second request is queued during the drain.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int delay,
                         input logic [31:0] rdata, input int clr_at,
                         input bit second, input logic [31:0] addr2);
    int  k;
    int  exp_k;
    bit  tout;
    bit  done;
    logic [31:0] rdata2;
    tout  = (delay > TO);
    exp_k = tout ? TO : delay;
    exp_q.push_back(tout ? ERR : rdata);
    if (clr_at >= 0 && clr_at <= exp_k) begin
      mdl_irq = 1'b0;
      mdl_cnt = 0;
    end
    if (tout) begin
      mdl_irq  = 1'b1;
      mdl_addr = addr;
      mdl_cnt  = (mdl_cnt >= 255) ? 255 : mdl_cnt + 1;
    end

    @(posedge clk_i); #1;
    s_valid_i = 1'b1;
    s_addr_i  = addr;
    s_wdata_i = wdata;
    s_wstrb_i = wstrb;
    k    = 0;
    done = 1'b0;
    while (!done && k <= TO + 4) begin
      m_ready_i = (k == delay);
      m_rdata_i = (k == delay) ? rdata : $urandom();
      to_clr_i  = (k == clr_at);
      @(negedge clk_i);
      chk("m_valid", m_valid_o, 1'b1);
      chk("m_req", {m_wstrb_o, m_addr_o}, {wstrb, addr});
      chk("m_wdata", m_wdata_o, wdata);
      done = s_ready_o;
      if (!done) begin
        k++;
        @(posedge clk_i); #1;
      end
    end
    chk("latency", k, exp_k);
    @(posedge clk_i); #1;
    s_valid_i = 1'b0;
    m_ready_i = 1'b0;
    to_clr_i  = 1'b0;

    if (tout) begin
      if (second) begin
        s_valid_i = 1'b1;
        s_addr_i  = addr2;
        s_wdata_i = $urandom();
        s_wstrb_i = 4'h0;
      end
      for (int j = TO + 1; j <= delay; j++) begin
        m_ready_i = (j == delay);
        m_rdata_i = $urandom();
        @(negedge clk_i);
        chk("drain_valid", m_valid_o, 1'b1);
        chk("drain_addr", m_addr_o, addr);
        chk("drain_stall", s_ready_o, 1'b0);
        if (j != delay) begin
          @(posedge clk_i); #1;
        end
      end
      @(posedge clk_i); #1;
      m_ready_i = 1'b0;
      if (second) begin
        rdata2 = $urandom();
        exp_q.push_back(rdata2);
        @(negedge clk_i);
        chk("second_valid", m_valid_o, 1'b1);
        chk("second_addr", m_addr_o, addr2);
        @(posedge clk_i); #1;
        m_ready_i = 1'b1;
        m_rdata_i = rdata2;
        @(negedge clk_i);
        chk("second_done", s_ready_o, 1'b1);
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
      end
    end
    @(negedge clk_i);
    check_record();
  endtask

  initial begin
    // reset values
    #1;
    chk("rst_m_valid", m_valid_o, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_record();
    chk("rst_s_ready", s_ready_o, 1'b0);
    rst_i = 1'b0;

    // zero-wait read
    run_txn(32'h0000_0100, 32'h0, 4'h0, 0, 32'h1234_5678, -1, 1'b0, 32'h0);
    // three wait cycles on a write
    run_txn(32'h1000_0004, 32'hCAFE_0001, 4'hF, 3, 32'h0, -1, 1'b0, 32'h0);
    // target never answers in time; drained shortly after
    run_txn(32'h2000_0010, 32'h0, 4'h0, 20, 32'h5555_AAAA, -1, 1'b0, 32'h0);
    // drain until cycle 40 with a second request stalled behind it
    run_txn(32'h2000_0020, 32'h0, 4'h0, 40, 32'h0, -1, 1'b1, 32'h3000_0008);
    // ready on exactly the last allowed cycle
    run_txn(32'h4000_0000, 32'h0, 4'h0, TO, 32'hABCD_0016, -1, 1'b0, 32'h0);
    // clear in the same cycle as a timeout
    run_txn(32'h5000_0040, 32'h0, 4'h0, TO + 3, 32'h0, TO, 1'b0, 32'h0);
    // clear earlier in a transaction that completes normally
    run_txn(32'h5000_0044, 32'h0, 4'h0, 5, 32'h7777_0005, 2, 1'b0, 32'h0);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      run_txn({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom(),
              4'($urandom_range(0, 15)), $urandom_range(0, TO + 8), $urandom(),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO) : -1,
              1'($urandom_range(0, 5) == 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
    end

    // saturation of the timeout count
    for (int i = 0; i < 300; i++) begin
      run_txn({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom(), 4'h0,
              TO + 1, $urandom(), -1, 1'b0, 32'h0);
    end
    chk("cnt_saturated", to_cnt_o, 8'd255);

    // reset in the middle of a wait
    @(posedge clk_i); #1;
    s_valid_i = 1'b1;
    s_addr_i  = 32'h6000_0000;
    s_wstrb_i = 4'h0;
    m_ready_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    chk("midwait_state", dbg_state_o, 2'd1);
    rst_i = 1'b1;
    mdl_irq  = 1'b0;
    mdl_cnt  = 0;
    mdl_addr = '0;
    #1;
    chk("rst_async_m_valid", m_valid_o, 1'b0);
    chk("rst_async_s_ready", s_ready_o, 1'b0);
    check_record();
    @(negedge clk_i);
    s_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    run_txn(32'h6000_0004, 32'h0, 4'h0, 2, 32'h0BAD_F00D, -1, 1'b0, 32'h0);

    repeat (3) @(posedge clk_i);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nmi_bus_timeout.md
Name: nmi_bus_timeout

Overview:
- Sits directly downstream of a user core's nmi master port, between the core and the SoC interconnect target.
- Passes valid/ready transactions through transparently.
- Counts wait cycles; if the target does not assert ready within TIMEOUT_CYC cycles, it completes the transaction to the core with an error read pattern so the core cannot hang.
- After a timeout it drains the stalled target request and records the event for software via a sticky IRQ, the faulting address and a saturating count.

Parameters:
- TIMEOUT_CYC, 1024: wait cycles allowed before forced completion. 0 disables the timeout (pure pass-through).
- CNT_W, 16: width of the internal wait counter. TIMEOUT_CYC must be less than 2^CNT_W.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned to the core on a forced completion.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- s_valid_i  in  1  request valid from core
- s_ready_o  out  1  request done to core
- s_addr_i  in  32  word-aligned address
- s_wdata_i  in  32  write data
- s_wstrb_i  in  4  byte strobes; 0 means read
- s_rdata_o  out  32  read data to core
- m_valid_o  out  1  request valid to target
- m_ready_i  in  1  target done
- m_addr_o  out  32  address to target
- m_wdata_o  out  32  write data to target
- m_wstrb_o  out  4  strobes to target
- m_rdata_i  in  32  read data from target
- to_clr_i  in  1  one-cycle pulse; clears to_irq_o and to_cnt_o
- to_irq_o  out  1  sticky timeout interrupt
- to_addr_o  out  32  address of the most recent timed-out request
- to_cnt_o  out  8  saturating timeout count

Behaviour:
- Upstream protocol: s_valid_i, once raised, stays high with addr, wdata and wstrb stable until s_ready_o.
- Reset values: state IDLE, counter 0, latched request regs 0, to_irq_o 0, to_addr_o 0, to_cnt_o 0.
- Reset asserted in any state (including WAIT or DRAIN) returns the block to IDLE. m_valid_o drops immediately on reset.
- State IDLE:
  - m_* follow s_* combinationally; s_ready_o = m_ready_i & s_valid_i; s_rdata_o = m_rdata_i.
  - If s_valid_i and m_ready_i: transaction completes with zero added latency; stay in IDLE.
  - If s_valid_i and not m_ready_i: latch addr, wdata and wstrb; counter = 1; go to WAIT.
- State WAIT:
  - m_* are driven from the latched regs; pass-through of ready and rdata as in IDLE.
  - If m_ready_i: complete; counter = 0; go to IDLE. A ready arriving in the same cycle the counter reaches TIMEOUT_CYC wins: normal completion, no timeout.
  - Else if counter == TIMEOUT_CYC (and TIMEOUT_CYC != 0):
    - s_ready_o = 1 and s_rdata_o = ERR_RDATA this cycle.
    - to_addr_o = latched addr; set to_irq_o; to_cnt_o increments, saturating at 255.
    - Go to DRAIN.
  - Else: counter increments.
- State DRAIN:
  - m_valid_o stays high with the latched request; s_ready_o = 0, so a new core request stalls.
  - On m_ready_i: discard m_rdata_i; go to IDLE. A new request from the core is accepted from the next cycle.
  - DRAIN has no timeout of its own.
- to_clr_i and a timeout event in the same cycle: the set wins. to_irq_o = 1 and to_cnt_o = 1.
- Writes that time out are reported identically. Write data may still land at the target during DRAIN.

Test Plan:
- Zero-wait read: s_valid_i with m_ready_i=1 and m_rdata_i=32'h1234_5678 in the same cycle -> s_ready_o=1 in that cycle, s_rdata_o=32'h1234_5678, state stays IDLE, to_irq_o=0.
- Wait 3 cycles (TIMEOUT_CYC=16), write to addr 32'h1000_0004 with wstrb 4'hF -> m_* stable for 4 cycles, s_ready_o pulses on cycle 4, no timeout.
- Target never responds (TIMEOUT_CYC=16), read of 32'h2000_0010:
  - s_ready_o pulses 16 cycles after s_valid_i with s_rdata_o=32'hDEAD_BEEF.
  - to_irq_o=1, to_addr_o=32'h2000_0010, to_cnt_o=1.
  - m_valid_o stays high.
- DRAIN then late ready: core issues a second request during DRAIN -> s_ready_o stays 0. m_ready_i at cycle 40 -> IDLE; the second request reaches the target the next cycle.
- Boundary cases:
  - m_ready_i exactly on cycle 16 -> normal completion, to_cnt_o unchanged.
  - to_clr_i in the same cycle as a timeout -> to_irq_o=1, to_cnt_o=1.
  - 300 timeouts -> to_cnt_o=255.
- Reset mid-WAIT: assert rst_i at cycle 5 of a wait -> m_valid_o=0 and all outputs at reset values immediately. After release, a fresh request completes normally.
